// File: rtl/arm_mem_pkg.sv
// Shared state type, default base address and SRAM bus widths for the data-memory
// SRAM interface.
package arm_mem_pkg;

    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam int unsigned WORD_IDX_W        = SRAM_ADDR_W - 1;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } sram_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts clocks spent in a halfword phase and flags the last one.
module sram_wait_counter #(
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [3:0] TC_VAL = 4'(PHASE_CYCLES - 1);

    logic [3:0] r_count;
    logic [3:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else if (i_en) begin
            w_count_next = r_count + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two 16-bit SRAM phases, freezing the pipe
// via ready. Define SRAM_ADDR_CHECK_EN to add range/alignment checking and addr_err.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N
`ifdef SRAM_ADDR_CHECK_EN
    ,
    output logic                   addr_err
`endif
);

    sram_state_e           r_state;
    sram_state_e           w_state_next;
    logic [WORD_IDX_W-1:0] r_word;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_is_wr;
    logic                  w_req;
    logic                  w_bad;
    logic                  w_tc;
    logic                  w_drive;
    logic [15:0]           w_dq_out;
    logic [31:0]           w_offset;

    assign w_req    = rd_en | wr_en;
    assign w_offset = address - BASE_ADDR;

`ifdef SRAM_ADDR_CHECK_EN
    logic r_err;
    logic w_unused_offset;

    assign w_bad = (address < BASE_ADDR) || (address[1:0] != 2'b00) || (w_offset[31:19] != '0);
    assign w_unused_offset = ^w_offset[1:0];
`else
    logic w_unused_offset;

    // Out-of-range words simply wrap onto the 2^17-word SRAM.
    assign w_bad = 1'b0;
    assign w_unused_offset = ^{w_offset[31:19], w_offset[1:0]};
`endif

    sram_wait_counter #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_wait_counter (
        .i_clk  (clk),
        .i_rst_n(reset),
        .i_clear(w_state_next != r_state),
        .i_en   ((r_state == StLow) || (r_state == StHigh)),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        ready        = ~w_req;
        SRAM_WE_N    = 1'b1;
        SRAM_ADDR    = '0;
        w_drive      = 1'b0;
        w_dq_out     = r_wdata[15:0];
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_state_next = w_bad ? StDone : StLow;
                end
            end
            StLow: begin
                SRAM_ADDR = {r_word, 1'b0};
                SRAM_WE_N = ~r_is_wr;
                w_drive   = r_is_wr;
                if (w_tc) begin
                    w_state_next = StHigh;
                end
            end
            StHigh: begin
                SRAM_ADDR = {r_word, 1'b1};
                SRAM_WE_N = ~r_is_wr;
                w_drive   = r_is_wr;
                w_dq_out  = r_wdata[31:16];
                if (w_tc) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                ready        = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign SRAM_DQ = w_drive ? w_dq_out : 'z;

    // Request is captured once in IDLE so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_word  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) && w_req) begin
                r_word  <= w_offset[WORD_IDX_W+1:2];
                r_wdata <= write_data;
                r_is_wr <= wr_en;
            end
            if (!r_is_wr && w_tc && (r_state == StLow)) begin
                r_rdata[15:0] <= SRAM_DQ;
            end
            if (!r_is_wr && w_tc && (r_state == StHigh)) begin
                r_rdata[31:16] <= SRAM_DQ;
            end
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if ((r_state == StIdle) && w_req) begin
            r_err <= w_bad;
        end
    end

    assign addr_err  = (r_state == StDone) && r_err;
    assign read_data = ((r_state == StDone) && r_err) ? '0 : r_rdata;
`else
    assign read_data = r_rdata;
`endif

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 2: SRAM clocks held per halfword phase, legal range 1..15.
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024: first byte address mapped to SRAM halfword 0.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rd_en  input  1  load request from EX/MEM register (MEM_R_EN).
REQ-006 SHALL have port wr_en  input  1  store request from EX/MEM register (MEM_W_EN).
REQ-007 SHALL have port address  input  32  byte address (EX ALU_result).
REQ-008 SHALL have port write_data  input  32  store data (EX Val_Rm_Exe).
REQ-009 SHALL have port read_data  output  32  registered load data.
REQ-010 SHALL have port ready  output  1  high = access complete or idle; low = pipeline freeze.
REQ-011 SHALL have port SRAM_DQ  inout  16  external SRAM data bus.
REQ-012 SHALL have port SRAM_ADDR  output  18  external SRAM halfword address.
REQ-013 SHALL have port SRAM_WE_N  output  1  external SRAM write enable, active low.

Function
REQ-014 Mapping SHALL be: word = (address - BASE_ADDR) >> 2; low half at SRAM_ADDR = {word[16:0],1'b0}, high half at {word[16:0],1'b1}.
REQ-015 FSM SHALL have states IDLE, LOW, HIGH, DONE; IDLE->LOW on rd_en|wr_en, LOW->HIGH and HIGH->DONE after PHASE_CYCLES clocks each, DONE->IDLE unconditionally.
REQ-016 ready SHALL be combinational: 1 when (rd_en|wr_en)==0 or state==DONE, else 0.
REQ-017 Access latency SHALL be 2*PHASE_CYCLES+1 clocks with ready low, ready high for exactly one clock (DONE).
REQ-018 Write SHALL drive SRAM_DQ = write_data[15:0] in LOW, write_data[31:16] in HIGH, SRAM_WE_N=0 in those states only.
REQ-019 Read SHALL latch SRAM_DQ into read_data[15:0] on last LOW clock, read_data[31:16] on last HIGH clock; read_data held until next read.
REQ-020 SRAM_DQ SHALL be high-Z and SRAM_WE_N=1 in IDLE, DONE and all read states.
REQ-021 rd_en and wr_en both high SHALL be treated as a write; rd_en ignored.
REQ-022 Request inputs SHALL be sampled only in IDLE; address/data/kind latched there; later input changes SHALL not affect the access in flight.
REQ-023 Request dropped mid-access SHALL not abort; FSM completes through DONE.
REQ-024 Phase counter SHALL be 4 bits, cleared on every state transition.

Reset
REQ-025 reset==0 at a clock edge SHALL force IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ high-Z, including mid-access (access discarded, no partial write beyond halfwords already written).

Configuration
REQ-026 With SRAM_ADDR_CHECK_EN defined, SHALL add output addr_err (1 bit) and treat address<BASE_ADDR, address[1:0]!=0, or word>=2^17 as error: IDLE->DONE directly, no SRAM strobe, addr_err=1 and read_data=0 in DONE only.
REQ-027 Without SRAM_ADDR_CHECK_EN, addr_err port SHALL be absent and out-of-range words SHALL wrap modulo 2^17.

Structure
REQ-028 Package arm_mem_pkg SHALL hold the state enum, BASE_ADDR default, SRAM address/data widths.
REQ-029 Phase counting SHALL live in sub-module sram_wait_counter (load/clear, terminal-count output).

Verification
REQ-030 Reset low 3 clocks mid-write -> next clock IDLE, SRAM_WE_N=1, DQ=Z, ready=1 with no request.
REQ-031 wr_en=1, address=1028, write_data=0xDEADBEEF, PHASE_CYCLES=2 -> SRAM_ADDR 2 then 3, DQ 0xBEEF then 0xDEAD, ready low 5 clocks, high on 6th.
REQ-032 rd_en=1, address=1028, SRAM model returns above data -> read_data=0xDEADBEEF in DONE clock.
REQ-033 rd_en=wr_en=1 -> write performed, read_data unchanged.
REQ-034 Back-to-back reads with rd_en held -> one clock of ready=1 between accesses, second access starts in following IDLE.
REQ-035 SRAM_ADDR_CHECK_EN, address=512 -> ready high after 1 clock, addr_err=1, SRAM_WE_N never low.
